// File: rtl/fb_layer_compositor.sv
// Per-frame back-buffer renderer: scrolled map plus colour-keyed sprite layers, or a saturating
// fade of the existing buffer. One pixel per clock through a 3-stage issue/data/write pipeline.
module fb_layer_compositor #(
    parameter int unsigned FB_W      = 240,
    parameter int unsigned FB_H      = 160,
    parameter int unsigned MAP_W     = 464,
    parameter int unsigned MAP_H     = 388,
    parameter int unsigned SHEET_W   = 271,
    parameter int unsigned SPR_W     = 16,
    parameter int unsigned SPR_H     = 21,
    parameter int unsigned NUM_SPR   = 2,
    parameter logic [23:0] KEY       = 24'hFF00FF,
    parameter int unsigned FADE_STEP = 1,
    parameter int unsigned AW        = 19
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    VGA_VS,
    input  logic [1:0]              mode,
    input  logic [9:0]              cam_x,
    input  logic [9:0]              cam_y,
    input  logic [NUM_SPR-1:0]      spr_en,
    input  logic [10*NUM_SPR-1:0]   spr_x,
    input  logic [10*NUM_SPR-1:0]   spr_y,
    input  logic [AW*NUM_SPR-1:0]   spr_base,
    output logic [AW-1:0]           map_addr,
    input  logic [23:0]             map_data,
    output logic [AW*NUM_SPR-1:0]   spr_addr,
    input  logic [24*NUM_SPR-1:0]   spr_data,
    output logic [AW-1:0]           fb_raddr,
    input  logic [23:0]             fb_rdata,
    output logic [AW-1:0]           fb_waddr,
    output logic [23:0]             fb_wdata,
    output logic                    fb_we,
    output logic                    busy,
    output logic                    pass_done,
    output logic                    fade_done,
    output logic                    overrun
);

    localparam logic [9:0] XLast   = 10'(FB_W - 1);
    localparam logic [9:0] YLast   = 10'(FB_H - 1);
    localparam logic [7:0] Step    = 8'(FADE_STEP);
    localparam logic [7:0] FadeMax = 8'((255 + FADE_STEP - 1) / FADE_STEP);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e state_q, state_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic       drain_q, drain_d;
    logic       vs_q;

    // Pass configuration captured at frame start
    logic                  fade_mode_q;
    logic [9:0]            cam_x_q, cam_y_q;
    logic [NUM_SPR-1:0]    spr_en_q;
    logic [10*NUM_SPR-1:0] spr_x_q, spr_y_q;
    logic [AW*NUM_SPR-1:0] spr_base_q;

    logic                  s1_valid_q, s1_last_q, s1_map_in_q;
    logic [AW-1:0]         s1_addr_q;
    logic [NUM_SPR-1:0]    s1_spr_hit_q;
    logic [23:0]           s1_pixel;

    logic                  fb_we_q, fb_last_q, pass_done_q, fade_done_q, overrun_q;
    logic [AW-1:0]         fb_waddr_q;
    logic [23:0]           fb_wdata_q;
    logic [7:0]            fade_cnt_q;

    logic                  frame_start, start, issue, last_issue, map_in;
    logic [10:0]           mx, my;
    logic [AW-1:0]         pix_addr;
    logic [NUM_SPR-1:0]    spr_hit;

    assign frame_start = vs_q & ~VGA_VS;
    assign start       = (state_q == StIdle) && frame_start && (mode == 2'd1 || mode == 2'd2);
    assign issue       = (state_q == StRun);
    assign last_issue  = issue && (x_q == XLast) && (y_q == YLast);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            StRun: begin
                if (x_q == XLast) begin
                    x_d = '0;
                    if (y_q == YLast) begin
                        state_d = StDrain;
                        y_d     = '0;
                        drain_d = 1'b0;
                    end else begin
                        y_d = y_q + 10'd1;
                    end
                end else begin
                    x_d = x_q + 10'd1;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StIdle;
                    drain_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 0: address generation from the pixel counters
    assign mx       = {1'b0, cam_x_q} + {1'b0, x_q};
    assign my       = {1'b0, cam_y_q} + {1'b0, y_q};
    assign map_in   = (mx < 11'(MAP_W)) && (my < 11'(MAP_H));
    assign pix_addr = AW'(y_q) * AW'(FB_W) + AW'(x_q);

    assign map_addr = (issue && !fade_mode_q && map_in) ? AW'(my) * AW'(MAP_W) + AW'(mx) : '0;
    assign fb_raddr = (issue && fade_mode_q) ? pix_addr : '0;

    // Unsigned offsets make sprites hanging off the left/top edge clip naturally
    for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
        logic [9:0] dx, dy;
        assign dx         = x_q - spr_x_q[10*g +: 10];
        assign dy         = y_q - spr_y_q[10*g +: 10];
        assign spr_hit[g] = spr_en_q[g] && (dx < 10'(SPR_W)) && (dy < 10'(SPR_H));
        assign spr_addr[AW*g +: AW] = (issue && !fade_mode_q && spr_hit[g])
            ? spr_base_q[AW*g +: AW] + AW'(dy) * AW'(SHEET_W) + AW'(dx) : '0;
    end

    function automatic logic [7:0] fade_ch(input logic [7:0] c);
        return (c < Step) ? 8'd0 : c - Step;
    endfunction

    // Stage 1: ROM/RAM data is valid; resolve layers in ascending priority
    always_comb begin
        s1_pixel = s1_map_in_q ? map_data : 24'h000000;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (s1_spr_hit_q[i] && (spr_data[24*i +: 24] != KEY)) begin
                s1_pixel = spr_data[24*i +: 24];
            end
        end
        if (fade_mode_q) begin
            s1_pixel = {fade_ch(fb_rdata[23:16]), fade_ch(fb_rdata[15:8]), fade_ch(fb_rdata[7:0])};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            drain_q      <= 1'b0;
            vs_q         <= 1'b0;
            fade_mode_q  <= 1'b0;
            cam_x_q      <= '0;
            cam_y_q      <= '0;
            spr_en_q     <= '0;
            spr_x_q      <= '0;
            spr_y_q      <= '0;
            spr_base_q   <= '0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_map_in_q  <= 1'b0;
            s1_addr_q    <= '0;
            s1_spr_hit_q <= '0;
            fb_we_q      <= 1'b0;
            fb_last_q    <= 1'b0;
            fb_waddr_q   <= '0;
            fb_wdata_q   <= '0;
            pass_done_q  <= 1'b0;
            fade_done_q  <= 1'b0;
            fade_cnt_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            vs_q    <= VGA_VS;
            if (start) begin
                fade_mode_q <= (mode == 2'd1);
                cam_x_q     <= cam_x;
                cam_y_q     <= cam_y;
                spr_en_q    <= spr_en;
                spr_x_q     <= spr_x;
                spr_y_q     <= spr_y;
                spr_base_q  <= spr_base;
            end
            if (frame_start && state_q != StIdle) overrun_q <= 1'b1;

            s1_valid_q   <= issue;
            s1_last_q    <= last_issue;
            s1_map_in_q  <= issue & map_in;
            s1_addr_q    <= issue ? pix_addr : '0;
            s1_spr_hit_q <= issue ? spr_hit : '0;

            fb_we_q     <= s1_valid_q;
            fb_last_q   <= s1_valid_q & s1_last_q;
            fb_waddr_q  <= s1_valid_q ? s1_addr_q : '0;
            fb_wdata_q  <= s1_valid_q ? s1_pixel : '0;
            pass_done_q <= fb_last_q;

            if (start && mode == 2'd2) begin
                fade_cnt_q  <= '0;
                fade_done_q <= 1'b0;
            end else if (fb_last_q && fade_mode_q && fade_cnt_q != FadeMax) begin
                fade_cnt_q <= fade_cnt_q + 8'd1;
                if (fade_cnt_q == FadeMax - 8'd1) fade_done_q <= 1'b1;
            end
        end
    end

    assign fb_we     = fb_we_q;
    assign fb_waddr  = fb_waddr_q;
    assign fb_wdata  = fb_wdata_q;
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign pass_done = pass_done_q;
    assign fade_done = fade_done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fb_layer_compositor.sv
// Bench for fb_layer_compositor on a reduced 40x24 framebuffer with FADE_STEP=64; ROMs and the
// framebuffer RAM are modelled here and each pass is compared against a per-pixel reference image.
module tb_fb_layer_compositor;

    localparam int FBW  = 40;
    localparam int FBH  = 24;
    localparam int N    = FBW * FBH;
    localparam int AW   = 19;
    localparam int NS   = 2;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic           Clk = 1'b0;
    logic           Reset, VGA_VS;
    logic [1:0]     mode;
    logic [9:0]     cam_x, cam_y;
    logic [NS-1:0]  spr_en;
    logic [10*NS-1:0] spr_x, spr_y;
    logic [AW*NS-1:0] spr_base;
    logic [AW-1:0]  map_addr, fb_raddr, fb_waddr;
    logic [23:0]    map_data, fb_rdata, fb_wdata;
    logic [AW*NS-1:0] spr_addr;
    logic [24*NS-1:0] spr_data;
    logic           fb_we, busy, pass_done, fade_done, overrun;

    logic           preload = 1'b0;
    logic [23:0]    ram [N];
    logic [23:0]    exp_img [N];

    int n_chk = 0;
    int n_fail = 0;

    // Pass configuration as the reference model sees it
    int cx, cy, ref_mode;
    int sx [NS];
    int sy [NS];
    int sbase [NS];
    bit sen [NS];

    fb_layer_compositor #(.FB_W(FBW), .FB_H(FBH), .FADE_STEP(64)) dut (
        .Clk(Clk), .Reset(Reset), .VGA_VS(VGA_VS), .mode(mode), .cam_x(cam_x), .cam_y(cam_y),
        .spr_en(spr_en), .spr_x(spr_x), .spr_y(spr_y), .spr_base(spr_base),
        .map_addr(map_addr), .map_data(map_data), .spr_addr(spr_addr), .spr_data(spr_data),
        .fb_raddr(fb_raddr), .fb_rdata(fb_rdata), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
        .fb_we(fb_we), .busy(busy), .pass_done(pass_done), .fade_done(fade_done),
        .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] texel(input int i, input logic [AW-1:0] a);
        return (a[2:0] == 3'd0) ? KEY : {8'h80 + 8'(i), 16'(a)};
    endfunction

    // ROMs and framebuffer RAM, all with one cycle of read latency
    always @(posedge Clk) begin
        map_data <= 24'(map_addr);
        for (int i = 0; i < NS; i++) spr_data[24*i +: 24] <= texel(i, spr_addr[AW*i +: AW]);
        fb_rdata <= ram[int'(fb_raddr) % N];
        if (preload) begin
            for (int k = 0; k < N; k++) ram[k] <= 24'hFFFFFF;
        end else if (fb_we) begin
            ram[int'(fb_waddr) % N] <= fb_wdata;
        end
    end

    function automatic logic [23:0] ref_compose(input int x, input int y);
        int mx, my, dx, dy;
        logic [23:0] p, t;
        mx = cx + x;
        my = cy + y;
        p = (mx < 464 && my < 388) ? 24'(my * 464 + mx) : 24'h000000;
        for (int i = 0; i < NS; i++) begin
            dx = x - sx[i];
            dy = y - sy[i];
            if (sen[i] && dx >= 0 && dx < 16 && dy >= 0 && dy < 21) begin
                t = texel(i, AW'(sbase[i] + dy * 271 + dx));
                if (t != KEY) p = t;
            end
        end
        return p;
    endfunction

    function automatic logic [23:0] ref_fade(input logic [23:0] p);
        logic [23:0] r;
        int c;
        for (int ch = 0; ch < 3; ch++) begin
            c = int'(p[8*ch +: 8]) - 64;
            if (c < 0) c = 0;
            r[8*ch +: 8] = 8'(c);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive_cfg();
        mode  = 2'(ref_mode);
        cam_x = 10'(cx);
        cam_y = 10'(cy);
        for (int i = 0; i < NS; i++) begin
            spr_en[i]           = sen[i];
            spr_x[10*i +: 10]   = 10'(sx[i]);
            spr_y[10*i +: 10]   = 10'(sy[i]);
            spr_base[AW*i +: AW] = AW'(sbase[i]);
        end
    endtask

    task automatic build_expected();
        for (int k = 0; k < N; k++) begin
            exp_img[k] = (ref_mode == 1) ? ref_fade(ram[k]) : ref_compose(k % FBW, k / FBW);
        end
    endtask

    task automatic frame_start();
        VGA_VS = 1'b1;
        tick();
        VGA_VS = 1'b0;
        tick();
    endtask

    // disturb: 0 none, 1 scramble inputs mid-pass, 2 second frame start mid-pass
    task automatic run_pass(input int disturb);
        bit ew, eb, ep;
        drive_cfg();
        build_expected();
        frame_start();
        if (ref_mode == 2) check("compose_clears_fade_done", 64'(fade_done), 64'd0);
        for (int c = 0; c <= N + 2; c++) begin
            eb = (c <= N + 1);
            ew = (c >= 2 && c <= N + 1);
            ep = (c == N + 2);
            check("ctl{busy,pass_done,we}", 64'({busy, pass_done, fb_we}), 64'({eb, ep, ew}));
            if (ew) check("write{addr,data}", 64'({fb_waddr, fb_wdata}),
                          64'({AW'(c - 2), exp_img[c - 2]}));
            if (disturb == 1 && c == 50) begin
                mode  = 2'($urandom_range(0, 3));
                cam_x = 10'($urandom);
                cam_y = 10'($urandom);
                spr_en = NS'($urandom);
                spr_x = 20'($urandom);
                spr_y = 20'($urandom);
                spr_base = 38'({$urandom, $urandom});
            end
            if (disturb == 2 && c == 100) VGA_VS = 1'b1;
            if (disturb == 2 && c == 101) VGA_VS = 1'b0;
            tick();
        end
    endtask

    task automatic random_cfg();
        cx = $urandom_range(0, 460);
        cy = $urandom_range(0, 385);
        for (int i = 0; i < NS; i++) begin
            sen[i]   = 1'($urandom);
            sx[i]    = int'($urandom_range(0, 70)) - 20;
            sy[i]    = int'($urandom_range(0, 50)) - 22;
            sbase[i] = $urandom_range(0, (1 << AW) - 1);
        end
    endtask

    initial begin
        Reset = 1'b1;
        VGA_VS = 1'b0;
        ref_mode = 0;
        cx = 0; cy = 0;
        for (int i = 0; i < NS; i++) begin
            sen[i] = 1'b0; sx[i] = 0; sy[i] = 0; sbase[i] = 0;
        end
        drive_cfg();
        repeat (3) tick();
        check("reset_flags", 64'({busy, pass_done, fade_done, overrun, fb_we}), 64'd0);
        check("reset_addrs", 64'({map_addr, fb_raddr, fb_waddr}), 64'd0);
        check("reset_wdata", 64'({fb_wdata, spr_addr}), 64'd0);
        Reset = 1'b0;
        tick();

        // Idle/reserved modes ignore frame start
        for (int m = 0; m < 4; m += 3) begin
            ref_mode = m;
            drive_cfg();
            frame_start();
            repeat (3) begin
                check("idle_mode_flags", 64'({busy, fb_we, pass_done}), 64'd0);
                check("idle_mode_addrs", 64'({map_addr, fb_raddr, spr_addr}), 64'd0);
                tick();
            end
        end

        // Map only, camera at origin
        ref_mode = 2;
        run_pass(0);
        check("overrun_quiet", 64'(overrun), 64'd0);

        // Camera near the map corner: right/bottom fall off to black
        cx = 440; cy = 370;
        run_pass(0);

        // Left/top clipped sprite 0 under sprite 1
        cx = 0; cy = 0;
        sen[0] = 1'b1; sx[0] = -4; sy[0] = -3; sbase[0] = 1000;
        sen[1] = 1'b1; sx[1] = 2;  sy[1] = 0;  sbase[1] = 5003;
        run_pass(0);

        repeat (3) begin
            random_cfg();
            run_pass(0);
        end

        // Inputs changing mid-pass must not leak into the pass
        random_cfg();
        run_pass(1);

        // Fade from white
        preload = 1'b1;
        tick();
        preload = 1'b0;
        tick();
        ref_mode = 1;
        for (int p = 1; p <= 5; p++) begin
            run_pass(0);
            check("fade_done_after_pass", 64'(fade_done), 64'(p >= 4));
        end
        check("fade_reaches_black", 64'(ram[N / 2]), 64'd0);

        // Compose clears fade_done at start; second frame start mid-pass flags overrun
        ref_mode = 2;
        random_cfg();
        run_pass(2);
        check("overrun_set", 64'(overrun), 64'd1);
        check("fade_done_cleared", 64'(fade_done), 64'd0);

        // Reset mid-pass aborts with no completion pulse
        frame_start();
        repeat (200) tick();
        check("busy_before_reset", 64'({busy, fb_we}), 64'b11);
        Reset = 1'b1;
        tick();
        check("reset_midpass", 64'({fb_we, busy, overrun, pass_done}), 64'd0);
        Reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("no_pass_done_after_reset", 64'({fb_we, pass_done, busy}), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
